// File: rtl/demux_1to2.sv
// demux_1to2: steers each accepted din word into one of two per-output FIFOs chosen by select.
// Latency: 1 cycle from the accepting edge to doutN_valid; no combinational din->dout path.
// Backpressure: din_ready = !full[select]; a stalled output only blocks words aimed at it.
// Optional: define DEMUX_STATS_EN to add saturating accepted-word counters cnt0/cnt1.

// Small synchronous FIFO: count-based full/empty, storage not reset.
module demux_1to2_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         vld_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en;
  logic          pop_en;

  assign vld_o  = (count_q != '0);
  assign full_o = (count_q == CW'(DEPTH));
  assign dat_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is ignored here as a safety net.
  always_comb begin
    push_en  = push_i && !full_o;
    pop_en   = pop_i && vld_o;
    wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_en) - CW'(pop_en);
  end

  // Pointer/occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

endmodule

module demux_1to2 #(
  parameter int width = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] din,
  input  logic             select,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [width-1:0] dout0,
  output logic             dout0_valid,
  input  logic             dout0_ready,
  output logic [width-1:0] dout1,
  output logic             dout1_valid,
  input  logic             dout1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  logic full0, full1;
  logic push0, push1;

  // Ready follows only the addressed FIFO so the other output keeps flowing.
  always_comb begin
    din_ready = select ? !full1 : !full0;
    push0     = din_valid && din_ready && !select;
    push1     = din_valid && din_ready && select;
  end

  demux_1to2_fifo #(.W(width), .DEPTH(DEPTH)) u_fifo0 (
    .clk    (clk),
    .reset  (reset),
    .push_i (push0),
    .pop_i  (dout0_ready),
    .dat_i  (din),
    .dat_o  (dout0),
    .vld_o  (dout0_valid),
    .full_o (full0)
  );

  demux_1to2_fifo #(.W(width), .DEPTH(DEPTH)) u_fifo1 (
    .clk    (clk),
    .reset  (reset),
    .push_i (push1),
    .pop_i  (dout1_ready),
    .dat_i  (din),
    .dat_o  (dout1),
    .vld_o  (dout1_valid),
    .full_o (full1)
  );

`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt0_d = (push0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = (push1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end

  // Accepted-word counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/demux_1to2.md
# demux_1to2

Registered 1-to-2 data steering block: the distribution-side counterpart of the datapath's 2:1 selectors. It accepts one `width`-bit word per valid/ready handshake and routes it to output 0 or output 1 according to `select`, buffering each output in its own small FIFO so a stalled destination does not lose data. It sits between a single producer, such as the bus or ALU result path, and two consumers, such as a register-file write port and an MMIO/memory write path.

## Interface
- `width`, 16: data word width in bits.
- `DEPTH`, 2: entries per output FIFO; a power of two, at least 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `din`  input  `width`  input data word.
- `select`  input  1  destination of `din`: 0 routes to output 0, 1 routes to output 1; sampled only when `din_valid` is high.
- `din_valid`  input  1  `din`/`select` are valid.
- `din_ready`  output  1  the block accepts the word this cycle.
- `dout0`, `dout1`  output  `width`  head-of-FIFO data for each output.
- `dout0_valid`, `dout1_valid`  output  1  the corresponding FIFO is non-empty.
- `dout0_ready`, `dout1_ready`  input  1  the corresponding consumer takes the head word.
- `cnt0`, `cnt1`  output  16  accepted-word counters; present only with `DEMUX_STATS_EN`.

## Operation
- Each output has its own FIFO. FIFO state:
  - write pointer and read pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`;
  - occupancy count, `$clog2(DEPTH)+1` bits.
- `din_ready` is combinational: `din_ready = !full[select]`. It does not depend on `din_valid`.
- Push: when `din_valid && din_ready`, write `din` to FIFO[`select`] and advance its write pointer. The other FIFO is untouched.
- Pop: when `doutN_valid && doutN_ready`, advance FIFO N's read pointer. `doutN_ready` while empty is ignored.
- Simultaneous push and pop on the same FIFO:
  - when not full: occupancy unchanged and both pointers advance;
  - when full: no push, because `din_ready` is low. There is no same-cycle slot reuse.
- Independent pops on both outputs in one cycle are allowed.
- `doutN` is driven from the FIFO storage at the read pointer. Its value is don't-care while `doutN_valid` is low; the bench must not check it.
- The block never drops, duplicates or reorders words. Per-output order equals acceptance order.
- Reset clears pointers, occupancies and counters. Storage contents are not reset.
- Reset mid-operation discards all buffered words. Outputs are invalid from the cycle after reset is sampled.

## Timing
- Reset values:
  - `dout0_valid` = `dout1_valid` = 0;
  - `din_ready` = 1 (both FIFOs empty);
  - `cnt0` = `cnt1` = 0;
  - `dout0`/`dout1` undefined.
- Latency: a word accepted at edge T appears on `doutN` with `doutN_valid` = 1 in the cycle after T. Minimum latency is one cycle, with no combinational `din`→`dout` path.
- Throughput: one word per cycle into a non-full FIFO. With `doutN_ready` held high, FIFO N sustains one word per cycle indefinitely at occupancy 1.
- Backpressure: with `doutN_ready` held low, FIFO N fills after `DEPTH` accepts. `din_ready` is then 0 whenever `select` = N, and remains 1 for `select` = other if that FIFO is not full.
- Full to not-full: a pop at edge T raises `din_ready` (for that `select`) in cycle T+1.
- Wrap-around: pointers roll from `DEPTH`-1 to 0 with no bubble.

## Configuration
- `DEMUX_STATS_EN` defined:
  - `cnt0`/`cnt1` ports exist;
  - each increments by 1 on every accepted push to its output;
  - each saturates at 16'hFFFF;
  - both clear on `reset`.
- `DEMUX_STATS_EN` undefined: the ports and counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset: assert `reset` for 2 cycles with `din_valid` = 1 → `dout0_valid` = `dout1_valid` = 0 and `din_ready` = 1 throughout and after. No word appears post-reset.
- Steering: send 16'h1111 (`select` = 0), 16'h2222 (`select` = 1), 16'h3333 (`select` = 0) on consecutive cycles, both readies high → output 0 shows 16'h1111 then 16'h3333. Output 1 shows 16'h2222, each one cycle after acceptance.
- Backpressure, `DEPTH` = 2:
  - hold `dout0_ready` = 0 and push 16'hA0, 16'hA1 to output 0 → a third push sees `din_ready` = 0;
  - pushes to output 1 still succeed;
  - raise `dout0_ready` → drains 16'hA0 then 16'hA1, and `din_ready` (`select` = 0) returns one cycle after the first pop.
- Wrap and simultaneity: stream 10 words to output 1 with `dout1_ready` toggling every cycle → all 10 are received in order and occupancy never exceeds `DEPTH`.
- Mid-operation reset: fill output 0 with 2 words, then pulse `reset` → `dout0_valid` = 0 next cycle. A subsequent push of 16'h5A5A is the first word out.
- Stats (`DEMUX_STATS_EN`): after 3 pushes to output 0 and 1 push to output 1 → `cnt0` = 3 and `cnt1` = 1. Preload to 16'hFFFE and push 3 → `cnt0` = 16'hFFFF.
